// File: rtl/dmaster_st_pkg.sv
// Shared Avalon-ST packet/byte framing definitions for the debug-master path.
// Used by both the packets-to-bytes encoder and the bytes-to-packets decoder.
package dmaster_st_pkg;

    localparam logic [7:0] SOP_CHAR  = 8'h7A;
    localparam logic [7:0] EOP_CHAR  = 8'h7B;
    localparam logic [7:0] CHAN_CHAR = 8'h7C;
    localparam logic [7:0] ESC_CHAR  = 8'h7D;
    localparam logic [7:0] ESC_XOR   = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CH_IND,
        ST_CH_ESC,
        ST_CH_BYTE,
        ST_SOP,
        ST_EOP,
        ST_D_ESC,
        ST_DATA
    } enc_state_e;

    function automatic logic is_special(input logic [7:0] b);
        return (b >= SOP_CHAR) && (b <= ESC_CHAR);
    endfunction

endpackage

// File: rtl/dmaster_p2b_encoder.sv
// Avalon-ST packets-to-bytes encoder: serialises one held packet beat into
// framing characters, optional channel sequence and escaped payload.
module dmaster_p2b_encoder
    import dmaster_st_pkg::*;
#(
    parameter int ENCODE_CHANNEL = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic [7:0] in_channel,
    input  logic       in_startofpacket,
    input  logic       in_endofpacket,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data
);

    enc_state_e state_q, state_d;
    logic [7:0] data_q, data_d;
    logic [7:0] chan_q, chan_d;
    logic       sop_q, sop_d;
    logic       eop_q, eop_d;
    logic       ch_sent_q, ch_sent_d;
    logic [7:0] last_ch_q, last_ch_d;

    logic       accept;
    logic       out_hs;

    function automatic enc_state_e after_eop(input logic [7:0] d);
        return is_special(d) ? ST_D_ESC : ST_DATA;
    endfunction

    function automatic enc_state_e after_sop(input logic eop, input logic [7:0] d);
        return eop ? ST_EOP : after_eop(d);
    endfunction

    function automatic enc_state_e after_chan(input logic sop, input logic eop,
                                              input logic [7:0] d);
        return sop ? ST_SOP : after_sop(eop, d);
    endfunction

    assign in_ready  = reset_n &&
                       ((state_q == ST_IDLE) || ((state_q == ST_DATA) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q != ST_IDLE);
    assign out_hs    = out_valid && out_ready;

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        chan_d    = chan_q;
        sop_d     = sop_q;
        eop_d     = eop_q;
        ch_sent_d = ch_sent_q;
        last_ch_d = last_ch_q;

        if (out_hs) begin
            case (state_q)
                ST_CH_IND:  state_d = is_special(chan_q) ? ST_CH_ESC : ST_CH_BYTE;
                ST_CH_ESC:  state_d = ST_CH_BYTE;
                ST_CH_BYTE: begin
                    ch_sent_d = 1'b1;
                    last_ch_d = chan_q;
                    state_d   = after_chan(sop_q, eop_q, data_q);
                end
                ST_SOP:     state_d = after_sop(eop_q, data_q);
                ST_EOP:     state_d = after_eop(data_q);
                ST_D_ESC:   state_d = ST_DATA;
                ST_DATA:    state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end

        // A new beat is only accepted from IDLE or from DATA on its final handshake,
        // so last_ch_q already reflects any channel this encoder has emitted.
        if (accept) begin
            data_d = in_data;
            chan_d = in_channel;
            sop_d  = in_startofpacket;
            eop_d  = in_endofpacket;
            if ((ENCODE_CHANNEL != 0) && (!ch_sent_q || (in_channel != last_ch_q))) begin
                state_d = ST_CH_IND;
            end else begin
                state_d = after_chan(in_startofpacket, in_endofpacket, in_data);
            end
        end
    end

    always_comb begin
        out_data = '0;
        case (state_q)
            ST_CH_IND:  out_data = CHAN_CHAR;
            ST_CH_ESC:  out_data = ESC_CHAR;
            ST_CH_BYTE: out_data = is_special(chan_q) ? (chan_q ^ ESC_XOR) : chan_q;
            ST_SOP:     out_data = SOP_CHAR;
            ST_EOP:     out_data = EOP_CHAR;
            ST_D_ESC:   out_data = ESC_CHAR;
            ST_DATA:    out_data = is_special(data_q) ? (data_q ^ ESC_XOR) : data_q;
            default:    out_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            chan_q    <= '0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            ch_sent_q <= 1'b0;
            last_ch_q <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            chan_q    <= chan_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
            ch_sent_q <= ch_sent_d;
            last_ch_q <= last_ch_d;
        end
    end

endmodule

// File: doc/dmaster_p2b_encoder.md
# dmaster_p2b_encoder

Avalon-ST packets-to-bytes encoder for the DDR3 EMIF debug-master path. It takes 8-bit packet beats carrying SOP, EOP and an 8-bit channel, and serialises them onto a plain byte stream. Framing is expressed with in-band special characters: 0x7A is SOP, 0x7B is EOP, 0x7C is the channel indicator and 0x7D is escape. This block is the transmit-side counterpart of the bytes-to-packets decoder/adapter chain. It sits between the master's response packet stream and the byte-level host link (JTAG/phy).

## Interface
- ENCODE_CHANNEL, default 1: 1 = emit channel sequences; 0 = never emit them (channel ignored).
- clk  in  1  sole clock, all logic rising-edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  packet beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_data  in  8  payload byte.
- in_channel  in  8  channel of beat.
- in_startofpacket  in  1  first beat of packet.
- in_endofpacket  in  1  last beat of packet.
- out_valid  out  1  byte valid.
- out_ready  in  1  downstream accepts byte when out_valid && out_ready.
- out_data  out  8  encoded byte.

## Operation
- One holding register captures data, channel, sop and eop on input handshake.
- The encoder then emits that beat's sequence in this fixed order; each element is emitted only if its condition holds.
- Channel indicator:
  - Condition: ENCODE_CHANNEL=1 and (no channel sent since reset, or in_channel != last_channel).
  - Emits 0x7C, then the channel byte.
  - The channel byte goes out as 0x7D, (ch^0x20) if ch is in 0x7A..0x7D.
  - last_channel updates when the channel byte is accepted.
- SOP: if sop, emit 0x7A.
- EOP: if eop, emit 0x7B, placed before the final data byte.
- Data: emit the byte; if it is in 0x7A..0x7D, emit 0x7D then (data^0x20).
- Therefore:
  - Minimum is 1 output byte per beat.
  - Maximum is 7 bytes: 7C,7D,ch^20,7A,7B,7D,d^20.
- FSM states: IDLE, CH_IND, CH_ESC, CH_BYTE, SOP, EOP, D_ESC, DATA.
  - IDLE goes to the first needed state of the captured beat.
  - Each state advances only on an output handshake, skipping elements whose condition is false.
  - DATA goes to IDLE, or directly to the first state of the next beat when a new beat is accepted in the same cycle.
- Packet legality (missing SOP/EOP) is not checked; the beat is encoded exactly as flagged.
- SOP and EOP on the same beat: emit both 0x7A then 0x7B.

## Timing
- Reset values: in_ready=0 during reset; after reset, in_ready=1 (IDLE).
  - out_valid=0, out_data=0x00, state=IDLE.
  - Channel-sent flag cleared, last_channel=0x00.
- Reset mid-sequence: the held beat is dropped. The next beat re-emits the channel sequence (if ENCODE_CHANNEL=1).
- Latency: a beat accepted at cycle N presents its first byte at N+1.
- out_valid/out_data derive from registered state and the holding register only; no combinational in→out path.
- in_ready = (state==IDLE) || (state==DATA && out_ready). This gives 1 byte/cycle sustained throughput for unescaped mid-packet beats on an unchanged channel.
- in_ready may depend combinationally on out_ready; no other in→out comb path.
- out_data is held stable while out_valid && !out_ready. out_valid never drops without a handshake.

## Structure
- Shared package dmaster_st_pkg holds:
  - Constants SOP_CHAR=8'h7A, EOP_CHAR=8'h7B, CHAN_CHAR=8'h7C, ESC_CHAR=8'h7D, ESC_XOR=8'h20.
  - The FSM state enum.
  - Function is_special(byte).
- The decoder side reuses the same package.
- There are no sub-modules; a single module of roughly 150–250 lines.

## Test plan
- Single-beat packet, ch=0, data=0x41, sop=eop=1, first after reset, out_ready=1 → bytes 7C,00,7A,7B,41. in_ready low for 4 cycles.
- 4-beat packet ch=0 data 11,22,33,44 after a prior ch=0 packet → 7A,11,22,33,7B,44. No channel sequence; back-to-back beats at 1 byte/cycle.
- Escaping: data 0x7A, 0x7D; channel 0x7C → 7C,7D,5C,7A,7D,5A,…,7B,7D,5D.
- Channel change mid-stream: ch 3 then ch 5 packets → 7C,03 before the first packet and 7C,05 before the second. ENCODE_CHANNEL=0 → no 7C ever emitted.
- Backpressure: out_ready toggled randomly, then held low 10 cycles mid-sequence → out_data stable and no bytes lost or duplicated. Byte stream identical to the out_ready=1 run.
- reset_n low for 1 cycle while in CH_BYTE → out_valid=0 the next cycle, beat dropped. Next beat (ch 0) emits 7C,00 again.
